// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared operand sizes, default line timing and receiver state encodings
package accel_pkg;

  localparam int NUM_OPERANDS = 12;
  localparam int OPERAND_W    = 8;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD     = 9600;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver with input synchronizer and mid-bit sampling
module uart_rx_byte
  import accel_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [OPERAND_W-1:0] data,
  output logic                 valid,
  output logic                 ferr,
  output logic                 line_idle
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  // Synchronizer and edge-history flops clear low, so a line held low across
  // reset release must be seen high before a falling edge can be detected.
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [OPERAND_W-1:0] shift_q, shift_d;

  // Receiver next-state, bit timing and one-cycle result pulses
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid   = 1'b0;
    ferr    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[OPERAND_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid = 1'b1;
          end else begin
            ferr = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Receiver state register
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign data      = shift_q;
  assign line_idle = (state_q == RX_IDLE);

endmodule

// File: rtl/uart_operand_loader.sv
// rtl/uart_operand_loader.sv - collects a 12-byte UART packet and commits it atomically to the accelerator operands
module uart_operand_loader
  import accel_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  output logic [OPERAND_W-1:0] a11,
  output logic [OPERAND_W-1:0] a12,
  output logic [OPERAND_W-1:0] a13,
  output logic [OPERAND_W-1:0] a21,
  output logic [OPERAND_W-1:0] a22,
  output logic [OPERAND_W-1:0] a23,
  output logic [OPERAND_W-1:0] a31,
  output logic [OPERAND_W-1:0] a32,
  output logic [OPERAND_W-1:0] a33,
  output logic [OPERAND_W-1:0] x1,
  output logic [OPERAND_W-1:0] x2,
  output logic [OPERAND_W-1:0] x3,
  output logic                 start,
  output logic                 busy,
  output logic                 frame_err
);

  localparam int            CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int            TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int            TW           = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST      = TW'(TO_CYCLES - 1);
  localparam int            IW           = $clog2(NUM_OPERANDS);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_OPERANDS - 1);

  logic [OPERAND_W-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ferr;
  logic                 rx_idle;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (RxD),
    .data     (rx_data),
    .valid    (rx_valid),
    .ferr     (rx_ferr),
    .line_idle(rx_idle)
  );

  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        to_q, to_d;
  logic [OPERAND_W-1:0] shadow_q [NUM_OPERANDS];
  logic [OPERAND_W-1:0] shadow_d [NUM_OPERANDS];
  logic [OPERAND_W-1:0] ops_q    [NUM_OPERANDS];
  logic [OPERAND_W-1:0] ops_d    [NUM_OPERANDS];
  logic                 start_q, start_d;
  logic                 ferr_q, ferr_d;

  // Byte collection, timeout and commit: the last byte bypasses the shadow so
  // all twelve operands land on the same edge as its stop-bit sample.
  always_comb begin
    idx_d    = idx_q;
    to_d     = '0;
    shadow_d = shadow_q;
    ops_d    = ops_q;
    start_d  = 1'b0;
    ferr_d   = 1'b0;
    if (rx_ferr) begin
      idx_d  = '0;
      ferr_d = 1'b1;
    end else if (rx_valid) begin
      shadow_d[idx_q] = rx_data;
      if (idx_q == IDX_LAST) begin
        for (int i = 0; i < NUM_OPERANDS - 1; i++) begin
          ops_d[i] = shadow_q[i];
        end
        ops_d[NUM_OPERANDS-1] = rx_data;
        idx_d   = '0;
        start_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else if ((idx_q != '0) && rx_idle) begin
      if (to_q == TO_LAST) begin
        idx_d = '0;
      end else begin
        to_d = to_q + TW'(1);
      end
    end
  end

  // Packet state and committed operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
      ferr_q  <= 1'b0;
      for (int i = 0; i < NUM_OPERANDS; i++) begin
        shadow_q[i] <= '0;
        ops_q[i]    <= '0;
      end
    end else begin
      idx_q    <= idx_d;
      to_q     <= to_d;
      start_q  <= start_d;
      ferr_q   <= ferr_d;
      shadow_q <= shadow_d;
      ops_q    <= ops_d;
    end
  end

  assign a11       = ops_q[0];
  assign a12       = ops_q[1];
  assign a13       = ops_q[2];
  assign a21       = ops_q[3];
  assign a22       = ops_q[4];
  assign a23       = ops_q[5];
  assign a31       = ops_q[6];
  assign a32       = ops_q[7];
  assign a33       = ops_q[8];
  assign x1        = ops_q[9];
  assign x2        = ops_q[10];
  assign x3        = ops_q[11];
  assign start     = start_q;
  assign frame_err = ferr_q;
  assign busy      = (idx_q != '0);

endmodule

// File: tb/tb_uart_operand_loader.sv
// tb/tb_uart_operand_loader.sv - directed vector bench for the UART operand loader
module tb_uart_operand_loader;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic [7:0] a11, a12, a13, a21, a22, a23, a31, a32, a33, x1, x2, x3;
  logic start, busy, frame_err;

  uart_operand_loader #(
    .CLK_FREQ    (153_600),
    .BAUD        (9600),
    .TIMEOUT_BITS(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (rxd),
    .a11      (a11),
    .a12      (a12),
    .a13      (a13),
    .a21      (a21),
    .a22      (a22),
    .a23      (a23),
    .a31      (a31),
    .a32      (a32),
    .a33      (a33),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .start    (start),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  wire [95:0] cur = {a11, a12, a13, a21, a22, a23, a31, a32, a33, x1, x2, x3};

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int start_cyc = 0;
  int start_cnt = 0;
  int ferr_cnt = 0;
  int mon_bad = 0;
  logic rst_prev = 1'b1;
  logic [95:0] last_ops = '0;
  logic [95:0] snaps [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Operands may change only in a start cycle (or right after reset);
  // start and frame_err must never overlap.
  always @(negedge clk) begin
    if (!rst_prev && !reset && (cur !== last_ops) && !start) begin
      mon_bad <= mon_bad + 1;
      $display("monitor: operands changed without start at cycle %0d", cyc);
    end
    if (start && frame_err) mon_bad <= mon_bad + 1;
    if (start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
      snaps.push_back(cur);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    last_ops <= cur;
    rst_prev <= reset;
  end

  typedef struct {
    logic [7:0] pkt [12];
    logic [7:0] exp [12];
  } vec_t;

  vec_t vt [3];

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop_bit;
    stop_cyc = cyc;
    tick(CPB);
    rxd = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] p [12]);
    for (int i = 0; i < 12; i++) send_byte(p[i], 1'b1);
  endtask

  function automatic logic [95:0] pack(input logic [7:0] p [12]);
    logic [95:0] r;
    for (int i = 0; i < 12; i++) r[95-8*i -: 8] = p[i];
    return r;
  endfunction

  task automatic chk_ops(input string nm, input logic [7:0] e [12]);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_op%0d", nm, i), {88'd0, cur[95-8*i -: 8]}, {88'd0, e[i]});
    end
  endtask

  initial begin
    int s0;
    int n0;
    int f0;
    logic [7:0] g [12];
    logic [7:0] ff [12];

    vt[0].pkt = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1};
    vt[0].exp = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1};
    vt[1].pkt = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    vt[1].exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    vt[2].pkt = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h7F, 8'hFE, 8'hC3, 8'h3C, 8'h55, 8'hAA};
    vt[2].exp = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h7F, 8'hFE, 8'hC3, 8'h3C, 8'h55, 8'hAA};
    g  = '{8'h21, 8'h42, 8'h63, 8'h84, 8'hA5, 8'hC6, 8'hE7, 8'h08, 8'h29, 8'h4A, 8'h6B, 8'h8C};
    ff = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // reset state
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_ops", cur, 96'd0);
    chk("rst_start", {95'd0, start}, 96'd0);
    chk("rst_busy", {95'd0, busy}, 96'd0);
    chk("rst_ferr", {95'd0, frame_err}, 96'd0);

    // framing error after four good bytes
    for (int i = 0; i < 4; i++) send_byte(vt[0].pkt[i], 1'b1);
    chk("ferr_busy_before", {95'd0, busy}, 96'd1);
    send_byte(8'h55, 1'b0);
    tick(20);
    chk("ferr_pulse_cycles", 96'(ferr_cnt), 96'd1);
    chk("ferr_busy_after", {95'd0, busy}, 96'd0);
    chk("ferr_ops", cur, 96'd0);
    chk("ferr_no_start", 96'(start_cnt), 96'd0);

    // table of full packets
    for (int v = 0; v < 3; v++) begin
      s0 = start_cnt;
      send_pkt(vt[v].pkt);
      tick(20);
      chk_ops($sformatf("vec%0d", v), vt[v].exp);
      chk($sformatf("vec%0d_starts", v), 96'(start_cnt - s0), 96'd1);
      chk($sformatf("vec%0d_start_lat", v),
          {95'd0, (start_cyc - stop_cyc >= 7) && (start_cyc - stop_cyc <= 15)}, 96'd1);
      chk($sformatf("vec%0d_busy", v), {95'd0, busy}, 96'd0);
    end

    // glitch between bytes
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) send_byte(g[i], 1'b1);
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(40);
    chk("glitch_busy", {95'd0, busy}, 96'd1);
    chk("glitch_ops_held", cur, pack(vt[2].exp));
    for (int i = 3; i < 12; i++) send_byte(g[i], 1'b1);
    tick(20);
    chk_ops("glitch", g);
    chk("glitch_starts", 96'(start_cnt - s0), 96'd1);

    // timeout after five bytes
    f0 = ferr_cnt;
    for (int i = 0; i < 5; i++) send_byte(vt[1].pkt[i], 1'b1);
    tick(15 * CPB - CPB);
    chk("to_busy_early", {95'd0, busy}, 96'd1);
    tick(40);
    chk("to_busy_late", {95'd0, busy}, 96'd0);
    chk("to_no_ferr", 96'(ferr_cnt - f0), 96'd0);
    s0 = start_cnt;
    send_pkt(ff);
    tick(20);
    chk_ops("to_ff", ff);
    chk("to_ff_starts", 96'(start_cnt - s0), 96'd1);

    // reset in the middle of a packet
    for (int i = 0; i < 7; i++) send_byte(vt[2].pkt[i], 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    chk("midrst_ops", cur, 96'd0);
    chk("midrst_busy", {95'd0, busy}, 96'd0);
    s0 = start_cnt;
    send_pkt(vt[0].pkt);
    tick(20);
    chk_ops("midrst_reload", vt[0].exp);
    chk("midrst_starts", 96'(start_cnt - s0), 96'd1);

    // back-to-back packets
    s0 = start_cnt;
    n0 = snaps.size();
    send_pkt(vt[1].pkt);
    send_pkt(vt[2].pkt);
    tick(20);
    chk("b2b_starts", 96'(start_cnt - s0), 96'd2);
    if (snaps.size() >= n0 + 2) begin
      chk("b2b_first", snaps[n0], pack(vt[1].exp));
      chk("b2b_second", snaps[n0+1], pack(vt[2].exp));
    end else begin
      chk("b2b_snapshots", 96'(snaps.size() - n0), 96'd2);
    end
    chk("b2b_final", cur, pack(vt[2].exp));

    chk("monitor_violations", 96'(mon_bad), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
